// File: rtl/video_stream_checker.sv
// AXI4-Stream video sink: drives tready, checks SOF/EOL framing,
// counts good frames and framing errors, latches a per-frame XOR.
module video_stream_checker #(
    parameter int          X_SIZE     = 480,
    parameter int          Y_SIZE     = 480,
    parameter int          READY_MODE = 1,
    parameter logic [32:0] RND_SEED   = 33'd1246504138,
    parameter int          CNT_W      = 16
) (
    input  logic             in_stream_aclk,
    input  logic             axi_resetn,
    input  logic [31:0]      in_stream_tdata,
    input  logic [3:0]       in_stream_tkeep,
    input  logic             in_stream_tlast,
    input  logic             in_stream_tuser,
    input  logic             in_stream_tvalid,
    output logic             in_stream_tready,
    input  logic             clear,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       err_flags,
    output logic             locked,
    output logic             frame_done,
    output logic [31:0]      frame_xor,
    output logic [15:0]      x_pos,
    output logic [15:0]      y_pos
);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    localparam logic [15:0] XL = 16'(X_SIZE - 1);
    localparam logic [15:0] YL = 16'(Y_SIZE - 1);

    state_t            state, state_n;
    logic [15:0]       x_n, y_n, cx, cy;
    logic [31:0]       rxor, rxor_n, fxor_n;
    logic              armed, armed_n;
    logic [32:0]       prbs, prbs_n;
    logic              ready_n;
    logic [CNT_W-1:0]  fc_n, ec_n;
    logic [CNT_W:0]    ec_sum;
    logic [3:0]        flags_n;
    logic [1:0]        inc;
    logic              done_n, eol, accept;
    logic              unused_keep;

    assign unused_keep = ^in_stream_tkeep;
    assign accept      = in_stream_tvalid & in_stream_tready;
    assign locked      = (state == IN_FRAME);

    always_ff @(posedge in_stream_aclk) begin
        if (!axi_resetn) begin
            state            <= WAIT_SOF;
            x_pos            <= '0;
            y_pos            <= '0;
            rxor             <= '0;
            armed            <= 1'b1;
            prbs             <= RND_SEED;
            in_stream_tready <= 1'b0;
            frame_count      <= '0;
            err_count        <= '0;
            err_flags        <= '0;
            frame_done       <= 1'b0;
            frame_xor        <= '0;
        end else begin
            state            <= state_n;
            x_pos            <= x_n;
            y_pos            <= y_n;
            rxor             <= rxor_n;
            armed            <= armed_n;
            prbs             <= prbs_n;
            in_stream_tready <= ready_n;
            frame_count      <= fc_n;
            err_count        <= ec_n;
            err_flags        <= flags_n;
            frame_done       <= done_n;
            frame_xor        <= fxor_n;
        end
    end

    always_comb begin
        prbs_n  = {prbs[31:0], prbs[32] ^ ~prbs[19]};
        ready_n = 1'b1;
        if (READY_MODE == 2)
            ready_n = prbs[32];
        else if (READY_MODE == 3)
            ready_n = in_stream_tvalid & ~accept;
    end

    always_comb begin
        state_n = state;
        x_n     = x_pos;
        y_n     = y_pos;
        cx      = x_pos;
        cy      = y_pos;
        rxor_n  = rxor;
        armed_n = armed;
        fc_n    = frame_count;
        flags_n = err_flags;
        fxor_n  = frame_xor;
        done_n  = 1'b0;
        inc     = 2'd0;
        eol     = 1'b0;
        if (accept) begin
            unique case (state)
                WAIT_SOF: begin
                    if (in_stream_tuser) begin
                        state_n = IN_FRAME;
                        cx      = '0;
                        cy      = '0;
                        rxor_n  = in_stream_tdata;
                        armed_n = 1'b1;
                        eol     = 1'b1;
                    end else if (armed) begin
                        flags_n[0] = 1'b1;
                        inc        = inc + 2'd1;
                        armed_n    = 1'b0;
                    end
                end
                IN_FRAME: begin
                    eol = 1'b1;
                    if (in_stream_tuser && (x_pos != '0 || y_pos != '0)) begin
                        flags_n[1] = 1'b1;
                        inc        = inc + 2'd1;
                        cx         = '0;
                        cy         = '0;
                        rxor_n     = in_stream_tdata;
                    end else begin
                        rxor_n = rxor ^ in_stream_tdata;
                    end
                end
            endcase
            // position check runs on the (possibly restarted) word position
            if (eol) begin
                if (cx == XL) begin
                    x_n = '0;
                    if (in_stream_tlast) begin
                        if (cy == YL) begin
                            done_n  = 1'b1;
                            fc_n    = frame_count + CNT_W'(1);
                            fxor_n  = rxor_n;
                            y_n     = '0;
                            state_n = WAIT_SOF;
                            armed_n = 1'b1;
                        end else begin
                            y_n = cy + 16'd1;
                        end
                    end else begin
                        flags_n[2] = 1'b1;
                        inc        = inc + 2'd1;
                        y_n        = '0;
                        state_n    = WAIT_SOF;
                    end
                end else if (in_stream_tlast) begin
                    flags_n[3] = 1'b1;
                    inc        = inc + 2'd1;
                    x_n        = '0;
                    if (cy == YL) begin
                        y_n     = '0;
                        state_n = WAIT_SOF;
                    end else begin
                        y_n = cy + 16'd1;
                    end
                end else begin
                    x_n = cx + 16'd1;
                    y_n = cy;
                end
            end
        end
        ec_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, inc};
        ec_n   = ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];
        if (clear) begin
            fc_n    = '0;
            ec_n    = '0;
            flags_n = '0;
            fxor_n  = '0;
        end
    end

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed bench for video_stream_checker at 4x3 frames:
// instance 0 always ready, instance 1 pseudo-random ready.
module tb_video_stream_checker;

    localparam int XS = 4;
    localparam int YS = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] tdata  [2];
    logic        tlast  [2];
    logic        tuser  [2];
    logic        tvalid [2];
    logic        tready [2];
    logic        clr    [2];
    logic [15:0] fc     [2];
    logic [15:0] ec     [2];
    logic [3:0]  flags  [2];
    logic        lock   [2];
    logic        fdone  [2];
    logic [31:0] fxor   [2];
    logic [15:0] xpos   [2];
    logic [15:0] ypos   [2];

    int n_chk = 0;
    int n_err = 0;
    int dcnt [2] = '{0, 0};
    int lowcnt = 0;

    always #5 clk = ~clk;

    video_stream_checker #(
        .X_SIZE(XS), .Y_SIZE(YS), .READY_MODE(1)
    ) u_dut (
        .in_stream_aclk  (clk),
        .axi_resetn      (rstn),
        .in_stream_tdata (tdata[0]),
        .in_stream_tkeep (4'hF),
        .in_stream_tlast (tlast[0]),
        .in_stream_tuser (tuser[0]),
        .in_stream_tvalid(tvalid[0]),
        .in_stream_tready(tready[0]),
        .clear           (clr[0]),
        .frame_count     (fc[0]),
        .err_count       (ec[0]),
        .err_flags       (flags[0]),
        .locked          (lock[0]),
        .frame_done      (fdone[0]),
        .frame_xor       (fxor[0]),
        .x_pos           (xpos[0]),
        .y_pos           (ypos[0])
    );

    video_stream_checker #(
        .X_SIZE(XS), .Y_SIZE(YS), .READY_MODE(2)
    ) u_dut_rnd (
        .in_stream_aclk  (clk),
        .axi_resetn      (rstn),
        .in_stream_tdata (tdata[1]),
        .in_stream_tkeep (4'hF),
        .in_stream_tlast (tlast[1]),
        .in_stream_tuser (tuser[1]),
        .in_stream_tvalid(tvalid[1]),
        .in_stream_tready(tready[1]),
        .clear           (clr[1]),
        .frame_count     (fc[1]),
        .err_count       (ec[1]),
        .err_flags       (flags[1]),
        .locked          (lock[1]),
        .frame_done      (fdone[1]),
        .frame_xor       (fxor[1]),
        .x_pos           (xpos[1]),
        .y_pos           (ypos[1])
    );

    always @(negedge clk) begin
        if (fdone[0]) dcnt[0]++;
        if (fdone[1]) dcnt[1]++;
        if (rstn && !tready[1]) lowcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int w, input logic [31:0] d, input logic u,
                        input logic l, input logic c);
        int n;
        @(negedge clk);
        tdata[w]  = d;
        tuser[w]  = u;
        tlast[w]  = l;
        tvalid[w] = 1'b1;
        clr[w]    = c;
        n = 0;
        while (!tready[w] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL ready_timeout: waited %0d cycles, limit 200", n);
        end
        @(posedge clk);
        #1;
        tvalid[w] = 1'b0;
        tuser[w]  = 1'b0;
        tlast[w]  = 1'b0;
        clr[w]    = 1'b0;
    endtask

    task automatic wword(input int w, input int idx, input logic [31:0] d);
        send(w, d, idx == 0, (idx % XS) == XS - 1, 1'b0);
    endtask

    task automatic frame(input int w, input logic [31:0] base);
        for (int i = 0; i < XS * YS; i++) wword(w, i, base + i);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            tdata[w] = '0; tlast[w] = 0; tuser[w] = 0;
            tvalid[w] = 0; clr[w] = 0;
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", tready[0], 0);
        chk("rst_tready_rnd", tready[1], 0);
        chk("rst_fc", fc[0], 0);
        chk("rst_ec", ec[0], 0);
        chk("rst_flags", flags[0], 0);
        chk("rst_locked", lock[0], 0);
        chk("rst_done", fdone[0], 0);
        chk("rst_fxor", fxor[0], 0);
        chk("rst_xy", {xpos[0], ypos[0]}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_on", tready[0], 1);
        chk("unlocked_idle", lock[0], 0);

        // three clean frames
        wword(0, 0, 0);
        chk("sof_locked", lock[0], 1);
        chk("sof_xy", {xpos[0], ypos[0]}, {16'd1, 16'd0});
        for (int i = 1; i < 12; i++) wword(0, i, i);
        chk("f1_done", fdone[0], 1);
        chk("f1_xor", fxor[0], 0);
        chk("f1_unlocked", lock[0], 0);
        frame(0, 0);
        frame(0, 1);
        repeat (2) @(negedge clk);
        chk("f3_dcnt", dcnt[0], 3);
        chk("f3_fc", fc[0], 3);
        chk("f3_xor", fxor[0], 32'hC);
        chk("f3_ec", ec[0], 0);
        chk("f3_done_low", fdone[0], 0);

        // stream joins mid-frame
        do_reset();
        for (int i = 5; i < 10; i++) send(0, i, 0, (i % XS) == XS - 1, 0);
        chk("mid_flags", flags[0], 4'h1);
        chk("mid_ec", ec[0], 1);
        chk("mid_locked", lock[0], 0);
        frame(0, 0);
        chk("mid_fc", fc[0], 1);
        chk("mid_ec2", ec[0], 1);

        // missing EOL on line 1
        do_reset();
        for (int i = 0; i < 7; i++) wword(0, i, i);
        send(0, 7, 0, 0, 0);
        chk("noeol_flags", flags[0], 4'h4);
        chk("noeol_ec", ec[0], 1);
        chk("noeol_locked", lock[0], 0);
        frame(0, 0);
        chk("noeol_fc", fc[0], 1);
        chk("noeol_ec2", ec[0], 1);

        // early EOL on word 1 of line 0
        do_reset();
        wword(0, 0, 32'h10);
        send(0, 32'h11, 0, 1, 0);
        chk("early_flags", flags[0], 4'h8);
        chk("early_ec", ec[0], 1);
        chk("early_xy", {xpos[0], ypos[0]}, {16'd0, 16'd1});
        chk("early_locked", lock[0], 1);
        for (int k = 0; k < 8; k++) send(0, 32'h20 + k, 0, (k % XS) == XS - 1, 0);
        chk("early_fc", fc[0], 1);
        chk("early_xor", fxor[0], 32'h1);

        // unexpected SOF on word 2 of line 1
        do_reset();
        for (int i = 0; i < 6; i++) wword(0, i, i);
        send(0, 32'h55, 1, 0, 0);
        chk("usof_flags", flags[0], 4'h2);
        chk("usof_ec", ec[0], 1);
        chk("usof_xy", {xpos[0], ypos[0]}, {16'd1, 16'd0});
        for (int i = 1; i < 12; i++) wword(0, i, i);
        chk("usof_fc", fc[0], 1);
        chk("usof_xor", fxor[0], 32'h55);

        // unexpected SOF and early EOL on one word
        do_reset();
        wword(0, 0, 0);
        send(0, 7, 1, 1, 0);
        chk("dbl_flags", flags[0], 4'hA);
        chk("dbl_ec", ec[0], 2);
        chk("dbl_xy", {xpos[0], ypos[0]}, {16'd0, 16'd1});

        // pseudo-random backpressure, clear on a completing word
        frame(1, 0);
        frame(1, 0);
        frame(1, 1);
        repeat (2) @(negedge clk);
        chk("rnd_dcnt", dcnt[1], 3);
        chk("rnd_fc", fc[1], 3);
        chk("rnd_ec", ec[1], 0);
        chk("rnd_xor", fxor[1], 32'hC);
        chk("rnd_stall_seen", lowcnt > 0, 1);
        for (int i = 0; i < 11; i++) wword(1, i, i);
        send(1, 11, 0, 1, 1);
        chk("clr_done", fdone[1], 1);
        chk("clr_fc", fc[1], 0);
        chk("clr_fxor", fxor[1], 0);
        chk("clr_unlocked", lock[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
